// File: rtl/mem_mpu_if.sv
// CPU-side request bus and memory-side bus of the memory protection unit.
// The slave modport is the MPU; the master modport is the CPU plus the memory.
interface mem_mpu_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  is_inst;
  logic                  cpu_valid;
  logic                  cpu_ready;
  logic [21:0]           cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [3:0]            cpu_wstrb;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic [3:0]            mem_wen;
  logic [21:0]           mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mpu_fault;

  modport slave (
    input  is_inst, cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, mem_rdata,
    output cpu_ready, cpu_rdata, mem_wen, mem_addr, mem_wdata, mpu_fault
  );

  modport master (
    output is_inst, cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, mem_rdata,
    input  cpu_ready, cpu_rdata, mem_wen, mem_addr, mem_wdata, mpu_fault
  );
endinterface

// File: rtl/mem_mpu.sv
// Memory protection unit: blocks data accesses to one word region; fetches always pass.
// Optional fault log (fault_count, fault_addr) is built when MEM_MPU_FAULT_LOG_EN is defined.
module mem_mpu #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MPU_START_ADDR = 768,
  parameter int unsigned MPU_LEN        = 16
) (
  input  logic        clk,
  input  logic        resetn,
  mem_mpu_if.slave    bus
`ifdef MEM_MPU_FAULT_LOG_EN
  ,
  output logic [15:0] fault_count,
  output logic [21:0] fault_addr
`endif
);

  typedef enum logic {StIdle, StResp} state_e;

  // 23-bit bounds so START+LEN at the top of the address space does not wrap.
  localparam logic [22:0] RegionLo = 23'(MPU_START_ADDR);
  localparam logic [22:0] RegionHi = 23'(MPU_START_ADDR + MPU_LEN);

  state_e                state_q, state_d;
  logic                  deny_q, deny_d;
  logic [22:0]           addr_ext;
  logic                  in_region;
  logic                  deny;
  logic [DATA_WIDTH-1:0] rdata;
  logic [3:0]            wen;
  logic                  ready;
  logic                  fault;

  assign addr_ext  = {1'b0, bus.cpu_addr};
  assign in_region = (addr_ext >= RegionLo) && (addr_ext < RegionHi);
  assign deny      = bus.cpu_valid && !bus.is_inst && in_region;

  always_comb begin
    state_d = state_q;
    deny_d  = deny_q;
    wen     = 4'b0000;
    ready   = 1'b0;
    fault   = 1'b0;
    rdata   = '0;
    // Outputs are held quiet while reset is asserted so an aborted request never completes.
    if (!resetn) begin
      unique case (state_q)
        StIdle: begin
          if (bus.cpu_valid) begin
            state_d = StResp;
            deny_d  = deny;
            wen     = deny ? 4'b0000 : bus.cpu_wstrb;
          end
        end
        StResp: begin
          state_d = StIdle;
          ready   = 1'b1;
          fault   = deny_q;
          rdata   = deny_q ? '0 : bus.mem_rdata;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= StIdle;
      deny_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      deny_q  <= deny_d;
    end
  end

  assign bus.cpu_ready = ready;
  assign bus.cpu_rdata = rdata;
  assign bus.mem_wen   = wen;
  assign bus.mpu_fault = fault;
  assign bus.mem_addr  = bus.cpu_addr;
  assign bus.mem_wdata = bus.cpu_wdata;

`ifdef MEM_MPU_FAULT_LOG_EN
  logic [15:0] fault_count_q;
  logic [21:0] fault_addr_q;

  always_ff @(posedge clk) begin
    if (resetn) begin
      fault_count_q <= 16'h0000;
      fault_addr_q  <= 22'h0;
    end else begin
      // Address is captured at acceptance since cpu_addr may move during the response.
      if (state_q == StIdle && deny) begin
        fault_addr_q <= bus.cpu_addr;
      end
      if (fault && fault_count_q != 16'hFFFF) begin
        fault_count_q <= fault_count_q + 16'h0001;
      end
    end
  end

  assign fault_count = fault_count_q;
  assign fault_addr  = fault_addr_q;
`endif

endmodule

// File: tb/tb_mem_mpu.sv
// Bench for mem_mpu: transaction-level reference model checked every cycle plus directed vectors.
module tb_mem_mpu;

  localparam int START = 768;
  localparam int LEN   = 16;

  logic clk;
  logic resetn;
  logic chk_en;
  int   n_cmp;
  int   n_bad;

  mem_mpu_if #(.DATA_WIDTH(32)) bus ();

`ifdef MEM_MPU_FAULT_LOG_EN
  logic [15:0] fault_count;
  logic [21:0] fault_addr;
`endif

  mem_mpu #(
    .DATA_WIDTH    (32),
    .MPU_START_ADDR(START),
    .MPU_LEN       (LEN)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
`ifdef MEM_MPU_FAULT_LOG_EN
    ,
    .fault_count(fault_count),
    .fault_addr (fault_addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with registered read; contents start as {16'hC0DE, addr} except word 10.
  logic [31:0] mem [0:1023];
  logic        mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
      mem[10] <= 32'h12345678;
      mem_init_done <= 1'b1;
    end else begin
      bus.mem_rdata <= mem[bus.mem_addr[9:0]];
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_wen[b]) mem[bus.mem_addr[9:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic denied(input logic inst, input logic [21:0] addr);
    int a;
    a = int'(addr);
    return !inst && a >= START && a < START + LEN;
  endfunction

  // Reference model: a request accepted when idle produces one response cycle next cycle.
  logic [31:0] ref_mem [0:1023];
  logic        ref_init = 1'b0;
  logic        m_resp;
  logic        m_flt;
  logic [31:0] m_data;
  logic        e_rdy, e_flt;
  logic [31:0] e_rd;
  logic [3:0]  e_wen;
  logic [9:0]  ix;

  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hC0DE0000 | 32'(i);
      ref_mem[10] = 32'h12345678;
      ref_init = 1'b1;
      m_resp   = 1'b0;
      m_flt    = 1'b0;
      m_data   = 32'h0;
    end
    if (chk_en) begin
      e_rdy = 1'b0;
      e_flt = 1'b0;
      e_rd  = 32'h0;
      e_wen = 4'h0;
      if (!resetn) begin
        if (m_resp) begin
          e_rdy = 1'b1;
          e_flt = m_flt;
          e_rd  = m_data;
        end else if (bus.cpu_valid) begin
          e_wen = denied(bus.is_inst, bus.cpu_addr) ? 4'h0 : bus.cpu_wstrb;
        end
      end
      check("model cpu_ready", 64'(bus.cpu_ready), 64'(e_rdy));
      check("model mpu_fault", 64'(bus.mpu_fault), 64'(e_flt));
      check("model cpu_rdata", 64'(bus.cpu_rdata), 64'(e_rd));
      check("model mem_wen", 64'(bus.mem_wen), 64'(e_wen));
      check("model mem_addr", 64'(bus.mem_addr), 64'(bus.cpu_addr));
      check("model mem_wdata", 64'(bus.mem_wdata), 64'(bus.cpu_wdata));

      if (resetn || m_resp) begin
        m_resp = 1'b0;
      end else if (bus.cpu_valid) begin
        ix     = bus.cpu_addr[9:0];
        m_flt  = denied(bus.is_inst, bus.cpu_addr);
        m_data = m_flt ? 32'h0 : ref_mem[ix];
        if (!m_flt) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.cpu_wstrb[b]) ref_mem[ix][8*b +: 8] = bus.cpu_wdata[8*b +: 8];
          end
        end
        m_resp = 1'b1;
      end
    end
  end

  task automatic req(input string tag, input logic inst, input logic [21:0] addr,
                     input logic [31:0] wd, input logic [3:0] ws, input logic [3:0] exp_wen,
                     input logic exp_flt, input logic [31:0] exp_rd);
    int n;
    @(posedge clk);
    #1;
    bus.is_inst   = inst;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    bus.cpu_wstrb = ws;
    bus.cpu_valid = 1'b1;
    @(negedge clk);
    check({tag, " wen"}, 64'(bus.mem_wen), 64'(exp_wen));
    n = 1;
    while (!bus.cpu_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd2);
    check({tag, " fault"}, 64'(bus.mpu_fault), 64'(exp_flt));
    check({tag, " rdata"}, 64'(bus.cpu_rdata), 64'(exp_rd));
    @(posedge clk);
    #1;
    bus.cpu_valid = 1'b0;
    bus.cpu_wstrb = 4'h0;
    bus.is_inst   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    chk_en        = 1'b0;
    resetn        = 1'b1;
    bus.is_inst   = 1'b0;
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = 22'd0;
    bus.cpu_wdata = 32'h0;
    bus.cpu_wstrb = 4'h0;

    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset cpu_ready", 64'(bus.cpu_ready), 64'd0);
    check("reset mpu_fault", 64'(bus.mpu_fault), 64'd0);
    check("reset mem_wen", 64'(bus.mem_wen), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b0;

    req("rd10", 1'b0, 22'd10, 32'h0, 4'h0, 4'h0, 1'b0, 32'h12345678);
    req("wr770", 1'b0, 22'd770, 32'hDEADBEEF, 4'hF, 4'h0, 1'b1, 32'h0);
    check("mem770 untouched", 64'(mem[770]), 64'hC0DE0302);
    req("rd770", 1'b0, 22'd770, 32'h0, 4'h0, 4'h0, 1'b1, 32'h0);
    req("fetch775", 1'b1, 22'd775, 32'h0, 4'h0, 4'h0, 1'b0, 32'hC0DE0307);
    req("rd767", 1'b0, 22'd767, 32'h0, 4'h0, 4'h0, 1'b0, 32'hC0DE02FF);
    req("rd768", 1'b0, 22'd768, 32'h0, 4'h0, 4'h0, 1'b1, 32'h0);
    req("rd783", 1'b0, 22'd783, 32'h0, 4'h0, 4'h0, 1'b1, 32'h0);
    req("rd784", 1'b0, 22'd784, 32'h0, 4'h0, 4'h0, 1'b0, 32'hC0DE0310);
    req("wr5", 1'b0, 22'd5, 32'hAABBCCDD, 4'b0011, 4'b0011, 1'b0, 32'hC0DE0005);
    check("mem5 low half", 64'(mem[5][15:0]), 64'hCCDD);
    check("mem5 high half", 64'(mem[5][31:16]), 64'hC0DE);
    req("rd5", 1'b0, 22'd5, 32'h0, 4'h0, 4'h0, 1'b0, 32'hC0DECCDD);

    // Back-to-back: valid held for two full request slots.
    @(posedge clk);
    #1;
    bus.cpu_addr  = 22'd784;
    bus.cpu_valid = 1'b1;
    @(negedge clk);
    check("b2b first idle ready", 64'(bus.cpu_ready), 64'd0);
    @(negedge clk);
    check("b2b first resp", 64'(bus.cpu_rdata), 64'hC0DE0310);
    @(negedge clk);
    check("b2b second idle ready", 64'(bus.cpu_ready), 64'd0);
    @(negedge clk);
    check("b2b second resp ready", 64'(bus.cpu_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.cpu_valid = 1'b0;

    // Reset during the response cycle of a denied read.
    @(posedge clk);
    #1;
    bus.cpu_addr  = 22'd770;
    bus.cpu_valid = 1'b1;
    @(posedge clk);
    #1;
    resetn        = 1'b1;
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    check("reset-in-resp ready", 64'(bus.cpu_ready), 64'd0);
    check("reset-in-resp fault", 64'(bus.mpu_fault), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    check("after reset ready", 64'(bus.cpu_ready), 64'd0);
`ifdef MEM_MPU_FAULT_LOG_EN
    check("fault_count after reset", 64'(fault_count), 64'd0);
    check("fault_addr after reset", 64'(fault_addr), 64'd0);
`endif
    req("post-reset rd10", 1'b0, 22'd10, 32'h0, 4'h0, 4'h0, 1'b0, 32'h12345678);
`ifdef MEM_MPU_FAULT_LOG_EN
    req("log rd771", 1'b0, 22'd771, 32'h0, 4'h0, 4'h0, 1'b1, 32'h0);
    @(negedge clk);
    check("fault_count one", 64'(fault_count), 64'd1);
    check("fault_addr 771", 64'(fault_addr), 64'd771);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
